// File: rtl/sv_buffer_pkg.sv
// Shared sizing helpers and defaults for the elastic-buffer family.
package sv_buffer_pkg;

  localparam int DEFAULT_DEPTH  = 8;
  localparam int DEFAULT_DATA_W = 8;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ring_counter.sv
// Modulo-WIDTH up/down counter, 0..WIDTH-1, wraps both ways; value is registered (1-cycle update).
// No backpressure: inc and dec together cancel.
module ring_counter
  import sv_buffer_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_DEPTH,
  localparam int PW    = ptr_w(WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          dec,
  output logic [PW-1:0] value
);

  localparam logic [PW-1:0] MAX = PW'(WIDTH - 1);

  logic [PW-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (inc && !dec) begin
      value_d = (value_q == MAX) ? '0 : value_q + PW'(1);
    end else if (dec && !inc) begin
      value_d = (value_q == '0) ? MAX : value_q - PW'(1);
    end
  end

  // rst_n is asserted high in this codebase.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/ring_fifo.sv
// Circular-buffer FIFO, first-word fall-through with 1-cycle write-to-read latency.
// in_ready = !full, out_valid = !empty, both from registered count; no cross-side ready paths.
module ring_fifo
  import sv_buffer_pkg::*;
#(
  parameter  int DEPTH  = DEFAULT_DEPTH,
  parameter  int DATA_W = DEFAULT_DATA_W,
  localparam int PW     = ptr_w(DEPTH),
  localparam int CW     = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic              push, pop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;
  assign out_data  = mem_q[rd_ptr];

  ring_counter #(.WIDTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (push),
    .dec   (1'b0),
    .value (wr_ptr)
  );

  ring_counter #(.WIDTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pop),
    .dec   (1'b0),
    .value (rd_ptr)
  );

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage is deliberately left unreset; contents are invisible while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr] <= in_data;
    end
  end

endmodule

// File: doc/ring_fifo.md
Name: ring_fifo

Overview:
- Circular-buffer FIFO with valid/ready handshakes on both sides.
- Built on two `ring_counter` instances: one write pointer, one read pointer.
- `ring_counter` counts 0..WIDTH-1 and wraps in both directions; `ring_fifo` uses it only as the pointer source and is its direct consumer.
- Sits between a producer and a consumer stage as the team's standard elastic buffer.

Parameters:
- DEPTH, 8, number of storage entries; legal range ≥ 2, power of two not required.
- DATA_W, 8, width of each stored word.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  reset, asynchronous, active-high (asserted = 1).
- in_valid  input  1  producer offers in_data this cycle.
- in_ready  output  1  FIFO accepts a word this cycle.
- in_data  input  DATA_W  write data.
- out_valid  output  1  out_data holds the oldest stored word.
- out_ready  input  1  consumer takes out_data this cycle.
- out_data  output  DATA_W  head-of-queue word.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Reset (rst_n = 1, async): wr_ptr = 0, rd_ptr = 0, count = 0.
  - Outputs during reset: empty = 1, full = 0, in_ready = 1, out_valid = 0.
  - Storage array is not reset. out_data is don't-care while empty.
- Handshake rules:
  - in_ready = !full and out_valid = !empty, both combinational from registered count.
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - Neither ready depends combinationally on the other side's valid/ready.
- Push: mem[wr_ptr] <= in_data. The write-pointer ring_counter gets inc = push, dec = 0.
- Pop: the read-pointer ring_counter gets inc = pop, dec = 0.
- Pointer wrap: DEPTH-1 -> 0, handled entirely by ring_counter (WIDTH = DEPTH).
- Output data: out_data = mem[rd_ptr], combinational read (first-word fall-through).
- Latency:
  - A word pushed in cycle N appears with out_valid = 1 in cycle N+1.
  - Empty-to-output bypass in the same cycle is not allowed.
- Count update:
  - push only: count + 1.
  - pop only: count - 1.
  - both or neither: unchanged.
  - count never exceeds DEPTH and never underflows, guaranteed by the ready gating.
- Simultaneous push and pop:
  - When 0 < count < DEPTH: both occur, count is unchanged, and both pointers advance.
  - When full: in_ready = 0, so only the pop occurs. in_ready rises the next cycle (no same-cycle pass-through).
  - When empty: out_valid = 0, so only the push occurs.
- Ignored inputs: in_valid while full and out_ready while empty have no effect.
- Derived flags: full and empty are decoded from count, never from pointer comparison.
- Reset mid-operation: all contents are discarded. From the first clock after rst_n deasserts, the FIFO behaves as empty.
- Input stability: in_data is sampled only on the push cycle. Producer and consumer need not hold signals stable after the handshake.

Decomposition:
- Shared package `sv_buffer_pkg`:
  - function ptr_w(depth) = $clog2(depth).
  - function cnt_w(depth) = $clog2(depth)+1.
  - localparam DEFAULT_DEPTH = 8, DEFAULT_DATA_W = 8.
- Sub-module: reuse the existing `ring_counter` (two instances: u_wr_ptr, u_rd_ptr) with WIDTH = DEPTH.
- Storage array, count register and flag decode stay inline in `ring_fifo`.

Test Plan:
- Reset check: hold rst_n = 1 for 3 cycles, then release -> count = 0, empty = 1, full = 0, in_ready = 1, out_valid = 0.
- Fill and drain (DEPTH = 8):
  - Push 0x10..0x17 with out_ready = 0 -> count reaches 8, full = 1, in_ready = 0. A 9th in_valid with 0xFF is ignored.
  - Then set out_ready = 1 -> data out in order 0x10..0x17, empty = 1 after 8 pops.
- Wrap-around: stream 20 words 0x00..0x13 with in_valid = out_ready = 1 after 3 words are preloaded -> order preserved across two pointer wraps, count held at 3.
- Full with simultaneous request: at count = 8, assert in_valid and out_ready together -> only the pop happens, count = 7 next cycle, then in_ready = 1.
- Empty latency: push 0xA5 into an empty FIFO at cycle N -> out_valid = 1 with out_data = 0xA5 at N+1, not at N.
- Reset mid-stream: with count = 5, pulse rst_n for 1 cycle -> count = 0 and empty = 1 immediately (async). The next push of 0x3C is the first word out.
